multi_cycle_cu: RTL
===================

# multi_cycle_cu

Multi-cycle control unit for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states, and drives the same control set as the single-cycle unit, plus PC/IR write enables. It sits between the instruction register and the datapath. The ALU opcode width is parametrised, and an optional memory wait handshake is available.

## Interface
- `ALUOP_W`, 3: width of `ALUOp`; `ALU_*` codes are zero-extended to this width.
- `CLK` input 1: single clock; all state changes occur on the rising edge.
- `Reset` input 1: synchronous, active-high; forces state to `ST_IF`.
- `Opcode` input 6: from the instruction register; stable from `ST_ID` onward.
- `Funct` input 6: from the instruction register.
- `Zero` input 1: ALU result == 0; sampled in `ST_EXE_BR`.
- `Sign` input 1: ALU result MSB; sampled in `ST_EXE_BR`.
- `MemReady` input 1: memory done; used only with `CU_MEM_WAIT_EN`.
- `PCWrite` output 1: PC load enable.
- `IRWrite` output 1: IR load enable.
- `ALUSrcA`, `ALUSrcB`, `RegDst`, `MemToReg`, `ExtSel` output 1 each: datapath selects with existing encodings.
- `MemRead` output 1: data memory read, active-low.
- `MemWrite` output 1: data memory write, active-low.
- `RegWrite` output 1: register file write enable.
- `PCSrc` output 2: `PC_NEXT_INS`, `PC_REL_JMP`, `PC_ABS_JMP` or `PC_HALT`.
- `ALUOp` output `ALUOP_W`: ALU function.
- `State` output 4: current state encoding, for debug.
- `Halted` output 1: high in `ST_HALT`.

## Operation
- States: `ST_IF`, `ST_ID`, `ST_EXE_AL`, `ST_EXE_LS`, `ST_EXE_BR`, `ST_MEM_LD`, `ST_MEM_ST`, `ST_WB_AL`, `ST_WB_LD`, `ST_HALT`.
- `ST_IF`: `IRWrite=1`, then go to `ST_ID`.
- `ST_ID`, branching on `Opcode`:
  - R-type, `ADDI`, `ORI` → `ST_EXE_AL`.
  - `LW`, `SW` → `ST_EXE_LS`.
  - `BEQ`, `BNE`, `BGTZ` → `ST_EXE_BR`.
  - `J`: `PCWrite=1`, `PCSrc=PC_ABS_JMP`, then `ST_IF`.
  - `HALT` → `ST_HALT`.
  - Any other opcode is a NOP: `PCWrite=1`, `PCSrc=PC_NEXT_INS`, then `ST_IF`.
- `ST_EXE_AL`: ALU selects and `ALUOp` per opcode/funct, identical to the single-cycle decode; then `ST_WB_AL`.
- `ST_WB_AL`: ALU selects held, `RegWrite=1`, `RegDst` = rt for `ADDI`/`ORI`, otherwise rd; `PCWrite=1` with `PC_NEXT_INS`; then `ST_IF`.
- `ST_EXE_LS`: `ALUSrcB=IMMD`, `ALUOp=ALU_ADD`, `ExtSel=SIGN`; `LW` → `ST_MEM_LD`, `SW` → `ST_MEM_ST`.
- `ST_MEM_LD`: `MemRead=0`, then `ST_WB_LD`.
- `ST_WB_LD`: `MemToReg=DATAMEMORY`, `RegDst=RT`, `RegWrite=1`, `PCWrite=1`, then `ST_IF`.
- `ST_MEM_ST`: `MemWrite=0`, `PCWrite=1`, then `ST_IF`.
- `ST_EXE_BR`: `ALUOp=ALU_SUB`, `PCWrite=1`, `PCSrc` decided by the existing Zero/Sign rules, then `ST_IF`.
- `ST_HALT`: `Halted=1`, `PCSrc=PC_HALT`, `PCWrite=0`; stays in `ST_HALT` until `Reset`.
- Outputs are a combinational decode of state + `Opcode`/`Funct` (Moore with respect to `Opcode`).
- Inactive values outside the states listed above:
  - `PCWrite`, `IRWrite`, `RegWrite` = 0.
  - `MemRead`, `MemWrite` = 1.
  - `PCSrc=PC_NEXT_INS`, `ALUOp=ALU_ADD`.
  - All selects at 0 / `FROM_DATA`.

## Timing
- Cycles per instruction:
  - J / NOP: 2.
  - Branch: 3.
  - ALU-type and `SW`: 4.
  - `LW`: 5.
- PC and register-file writes occur on the edge that leaves the final state of the instruction; `IRWrite` captures on the edge leaving `ST_IF`.
- While `Reset`=1, every output is forced to its inactive value and `State=ST_IF`. Reset in any state, including `ST_HALT` or mid-`LW`, takes effect at the next edge; no write enable is active during that cycle.
- The branch decision uses `Zero`/`Sign` in the same cycle as `PCWrite`; there is no registered flag.

## Configuration
- `CU_MEM_WAIT_EN` defined:
  - `ST_IF`, `ST_MEM_LD` and `ST_MEM_ST` hold while `MemReady`=0, with the memory strobe held active.
  - `IRWrite` is asserted only in the cycle `MemReady`=1.
  - `PCWrite` in `ST_MEM_ST` is asserted only when `MemReady`=1.
- `CU_MEM_WAIT_EN` undefined: `MemReady` is ignored and each of these states lasts exactly 1 cycle.

## Structure
- `Constants.v` gains the `ST_*` 4-bit state encodings beside the existing `OP_*`, `FUNCT_*`, `ALU_*`, `PC_*` and select macros.
- One sub-module, `cu_op_decode`: combinational; takes `Opcode` and `Funct` and outputs the instruction class (ALU/LS/BR/J/HALT/NOP) and the execute-phase `ALUOp`/select values. The FSM contains no opcode tables.

## Test plan
- Reset held 2 cycles then released, `Opcode`=`000000` `Funct`=`100000` (add) → `State` goes IF, ID, EXE_AL, WB_AL, IF; `RegWrite`=1 and `PCWrite`=1 only in WB_AL; `ALUOp=ALU_ADD`.
- `LW` (`100011`) → 5 cycles; `MemRead`=0 only in MEM_LD; `MemToReg`=1 and `RegDst=RT` in WB_LD.
- `BEQ` (`000100`) with `Zero`=1 → `PCSrc=PC_REL_JMP` in EXE_BR. `BNE` with `Zero`=1 → `PC_NEXT_INS`. `BGTZ` with `Sign`=0, `Zero`=0 → `PC_REL_JMP`.
- `J` (`000010`) → 2 cycles, `PCSrc=PC_ABS_JMP` and `PCWrite`=1 in ID. Unknown opcode `010101` → NOP, 2 cycles, no `RegWrite`.
- `HALT` (`111111`) → `Halted`=1 persists for 10 cycles; `Reset` pulse → `ST_IF` next edge and `Halted`=0.
- With `CU_MEM_WAIT_EN`: `SW` with `MemReady`=0 for 3 cycles → `MemWrite`=0 for 4 cycles, `PCWrite` only in the last; `Reset` asserted mid-wait → IF next edge.

Source files
------------

// File: rtl/multi_cycle_cu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds the 4-bit ST_* state encodings alongside the opcode, funct,
// ALU, PC-source and datapath-select encodings used by the datapath,
// the instruction-class enum produced by the opcode decoder, and the
// branch-resolution helper.
package multi_cycle_cu_pkg;

    typedef enum logic [3:0] {
        ST_IF     = 4'd0,
        ST_ID     = 4'd1,
        ST_EXE_AL = 4'd2,
        ST_EXE_LS = 4'd3,
        ST_EXE_BR = 4'd4,
        ST_MEM_LD = 4'd5,
        ST_MEM_ST = 4'd6,
        ST_WB_AL  = 4'd7,
        ST_WB_LD  = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LS,
        CLS_BR,
        CLS_J,
        CLS_HALT,
        CLS_NOP
    } instr_class_t;

    typedef enum logic [1:0] {
        BR_EQ,
        BR_NE,
        BR_GTZ
    } br_kind_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // R-type function codes
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU functions, zero-extended to ALUOP_W where used
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;

    // PC source
    localparam logic [1:0] PC_NEXT_INS = 2'd0;
    localparam logic [1:0] PC_REL_JMP  = 2'd1;
    localparam logic [1:0] PC_ABS_JMP  = 2'd2;
    localparam logic [1:0] PC_HALT     = 2'd3;

    // Datapath selects; FROM_DATA (0) is the inactive value of every select
    localparam logic FROM_DATA      = 1'b0;
    localparam logic SRCA_SHAMT     = 1'b1;
    localparam logic SRCB_IMMD      = 1'b1;
    localparam logic DST_RT         = 1'b0;
    localparam logic DST_RD         = 1'b1;
    localparam logic MEM_DATAMEMORY = 1'b1;
    localparam logic EXT_ZERO       = 1'b0;
    localparam logic EXT_SIGN       = 1'b1;

    // Branch resolution from the ALU flags of rs - rt (BGTZ uses rs - 0).
    function automatic logic [1:0] branch_pc_src(input br_kind_t kind,
                                                 input logic zero,
                                                 input logic sign);
        logic taken;
        case (kind)
            BR_EQ:   taken = zero;
            BR_NE:   taken = !zero;
            default: taken = !zero && !sign;
        endcase
        return taken ? PC_REL_JMP : PC_NEXT_INS;
    endfunction

endpackage

// File: rtl/multi_cycle_cu_if.sv
// Control bus between the multi-cycle control unit and the datapath.
// master: control unit side (receives IR fields / ALU flags / MemReady,
//         drives write enables, selects, PC source, ALU op, debug state).
// slave:  datapath side (the mirror image).
interface multi_cycle_cu_if #(
    parameter int ALUOP_W = 3
);
    logic [5:0]         Opcode;
    logic [5:0]         Funct;
    logic               Zero;
    logic               Sign;
    logic               MemReady;
    logic               PCWrite;
    logic               IRWrite;
    logic               ALUSrcA;
    logic               ALUSrcB;
    logic               RegDst;
    logic               MemToReg;
    logic               ExtSel;
    logic               MemRead;
    logic               MemWrite;
    logic               RegWrite;
    logic [1:0]         PCSrc;
    logic [ALUOP_W-1:0] ALUOp;
    logic [3:0]         State;
    logic               Halted;

    modport master (
        input  Opcode, Funct, Zero, Sign, MemReady,
        output PCWrite, IRWrite, ALUSrcA, ALUSrcB, RegDst, MemToReg, ExtSel,
               MemRead, MemWrite, RegWrite, PCSrc, ALUOp, State, Halted
    );

    modport slave (
        output Opcode, Funct, Zero, Sign, MemReady,
        input  PCWrite, IRWrite, ALUSrcA, ALUSrcB, RegDst, MemToReg, ExtSel,
               MemRead, MemWrite, RegWrite, PCSrc, ALUOp, State, Halted
    );
endinterface

// File: rtl/multi_cycle_cu_op_decode.sv
// cu_op_decode: combinational opcode/funct decoder for the multi-cycle CU.
// Inputs:  opcode, funct (instruction register fields).
// Outputs: instr_class (ALU/LS/BR/J/HALT/NOP), br_kind, execute-phase
//          alu_op / alu_src_a / alu_src_b / ext_sel, write-back reg_dst,
//          is_load (LW vs SW within the LS class).
module cu_op_decode
    import multi_cycle_cu_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output instr_class_t       instr_class,
    output br_kind_t           br_kind,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_src_a,
    output logic               alu_src_b,
    output logic               ext_sel,
    output logic               reg_dst,
    output logic               is_load
);

    always_comb begin
        instr_class = CLS_NOP;
        br_kind     = BR_EQ;
        alu_op      = ALUOP_W'(ALU_ADD);
        alu_src_a   = FROM_DATA;
        alu_src_b   = FROM_DATA;
        ext_sel     = EXT_ZERO;
        reg_dst     = DST_RD;
        is_load     = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                instr_class = CLS_ALU;
                case (funct)
                    FUNCT_ADD: alu_op = ALUOP_W'(ALU_ADD);
                    FUNCT_SUB: alu_op = ALUOP_W'(ALU_SUB);
                    FUNCT_AND: alu_op = ALUOP_W'(ALU_AND);
                    FUNCT_OR:  alu_op = ALUOP_W'(ALU_OR);
                    FUNCT_SLT: alu_op = ALUOP_W'(ALU_SLT);
                    FUNCT_SLL: begin
                        alu_op    = ALUOP_W'(ALU_SLL);
                        alu_src_a = SRCA_SHAMT;
                    end
                    default:   alu_op = ALUOP_W'(ALU_ADD);
                endcase
            end
            OP_ADDI: begin
                instr_class = CLS_ALU;
                alu_src_b   = SRCB_IMMD;
                ext_sel     = EXT_SIGN;
                reg_dst     = DST_RT;
            end
            OP_ORI: begin
                instr_class = CLS_ALU;
                alu_op      = ALUOP_W'(ALU_OR);
                alu_src_b   = SRCB_IMMD;
                ext_sel     = EXT_ZERO;
                reg_dst     = DST_RT;
            end
            OP_LW, OP_SW: begin
                instr_class = CLS_LS;
                alu_src_b   = SRCB_IMMD;
                ext_sel     = EXT_SIGN;
                reg_dst     = DST_RT;
                is_load     = (opcode == OP_LW);
            end
            OP_BEQ: begin
                instr_class = CLS_BR;
                br_kind     = BR_EQ;
                alu_op      = ALUOP_W'(ALU_SUB);
            end
            OP_BNE: begin
                instr_class = CLS_BR;
                br_kind     = BR_NE;
                alu_op      = ALUOP_W'(ALU_SUB);
            end
            OP_BGTZ: begin
                instr_class = CLS_BR;
                br_kind     = BR_GTZ;
                alu_op      = ALUOP_W'(ALU_SUB);
            end
            OP_J:    instr_class = CLS_J;
            OP_HALT: instr_class = CLS_HALT;
            default: instr_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/multi_cycle_cu.sv
// multi_cycle_cu: multi-cycle MIPS control unit.
// Sequences each instruction IF -> ID -> EXE -> (MEM) -> (WB) and drives
// the datapath control set plus PC/IR write enables.
// Ports: CLK (rising edge), Reset (synchronous, active-high),
//        bus (multi_cycle_cu_if.master: IR fields, ALU flags, MemReady in;
//        control outputs, debug State and Halted out).
// Outputs are a combinational decode of state + opcode/funct, so the
// branch decision follows Zero/Sign within the EXE_BR cycle.
// Optional: define CU_MEM_WAIT_EN to make IF, MEM_LD and MEM_ST wait for
// MemReady; otherwise MemReady is ignored and those states last 1 cycle.
module multi_cycle_cu
    import multi_cycle_cu_pkg::*;
#(
    parameter int ALUOP_W = 3
) (
    input logic              CLK,
    input logic              Reset,
    multi_cycle_cu_if.master bus
);

    state_t             state;
    instr_class_t       instr_class;
    br_kind_t           br_kind;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic               dec_src_a;
    logic               dec_src_b;
    logic               dec_ext;
    logic               dec_reg_dst;
    logic               dec_is_load;
    logic               mem_ready;

`ifdef CU_MEM_WAIT_EN
    assign mem_ready = bus.MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.MemReady;
    assign mem_ready        = 1'b1;
`endif

    cu_op_decode #(
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .opcode      (bus.Opcode),
        .funct       (bus.Funct),
        .instr_class (instr_class),
        .br_kind     (br_kind),
        .alu_op      (dec_alu_op),
        .alu_src_a   (dec_src_a),
        .alu_src_b   (dec_src_b),
        .ext_sel     (dec_ext),
        .reg_dst     (dec_reg_dst),
        .is_load     (dec_is_load)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= ST_IF;
        end else begin
            case (state)
                ST_IF:     if (mem_ready) state <= ST_ID;
                ST_ID: begin
                    case (instr_class)
                        CLS_ALU:  state <= ST_EXE_AL;
                        CLS_LS:   state <= ST_EXE_LS;
                        CLS_BR:   state <= ST_EXE_BR;
                        CLS_HALT: state <= ST_HALT;
                        default:  state <= ST_IF;
                    endcase
                end
                ST_EXE_AL: state <= ST_WB_AL;
                ST_EXE_LS: state <= dec_is_load ? ST_MEM_LD : ST_MEM_ST;
                ST_EXE_BR: state <= ST_IF;
                ST_MEM_LD: if (mem_ready) state <= ST_WB_LD;
                ST_MEM_ST: if (mem_ready) state <= ST_IF;
                ST_WB_AL:  state <= ST_IF;
                ST_WB_LD:  state <= ST_IF;
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_IF;
            endcase
        end
    end

    // Reset overrides the state register combinationally so the reset cycle
    // itself shows ST_IF with every enable inactive.
    assign bus.State = Reset ? ST_IF : state;

    always_comb begin
        bus.PCWrite  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b1;
        bus.PCSrc    = PC_NEXT_INS;
        bus.ALUOp    = ALUOP_W'(ALU_ADD);
        bus.ALUSrcA  = FROM_DATA;
        bus.ALUSrcB  = FROM_DATA;
        bus.RegDst   = FROM_DATA;
        bus.MemToReg = FROM_DATA;
        bus.ExtSel   = FROM_DATA;
        bus.Halted   = 1'b0;

        if (!Reset) begin
            case (state)
                ST_IF: bus.IRWrite = mem_ready;
                ST_ID: begin
                    if (instr_class == CLS_J) begin
                        bus.PCWrite = 1'b1;
                        bus.PCSrc   = PC_ABS_JMP;
                    end else if (instr_class == CLS_NOP) begin
                        bus.PCWrite = 1'b1;
                    end
                end
                ST_EXE_AL, ST_EXE_LS: begin
                    bus.ALUOp   = dec_alu_op;
                    bus.ALUSrcA = dec_src_a;
                    bus.ALUSrcB = dec_src_b;
                    bus.ExtSel  = dec_ext;
                end
                ST_WB_AL: begin
                    bus.ALUOp    = dec_alu_op;
                    bus.ALUSrcA  = dec_src_a;
                    bus.ALUSrcB  = dec_src_b;
                    bus.ExtSel   = dec_ext;
                    bus.RegDst   = dec_reg_dst;
                    bus.RegWrite = 1'b1;
                    bus.PCWrite  = 1'b1;
                end
                ST_MEM_LD: bus.MemRead = 1'b0;
                ST_WB_LD: begin
                    bus.MemToReg = MEM_DATAMEMORY;
                    bus.RegDst   = DST_RT;
                    bus.RegWrite = 1'b1;
                    bus.PCWrite  = 1'b1;
                end
                ST_MEM_ST: begin
                    bus.MemWrite = 1'b0;
                    bus.PCWrite  = mem_ready;
                end
                ST_EXE_BR: begin
                    bus.ALUOp   = dec_alu_op;
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = branch_pc_src(br_kind, bus.Zero, bus.Sign);
                end
                ST_HALT: begin
                    bus.Halted = 1'b1;
                    bus.PCSrc  = PC_HALT;
                end
                default: ;
            endcase
        end
    end

endmodule
